// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and core
// control/status outputs of the boot loader, bundled so the loader and its
// environment connect through one port.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  // Stream source / system side: drives bytes and restart, observes the loader.
  modport master (
    output in_valid, in_data, restart,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, word_count
  );

  // Loader side: consumes bytes, writes memory, controls the core reset.
  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a framed little-endian byte
// stream (LEN_LO, LEN_HI, 4*N payload bytes, CHK), writes each assembled
// 32-bit word to instruction memory and keeps the core in reset until the
// whole image has been written and its XOR checksum verified.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] MaxWordsC = 17'(MAX_WORDS);

  state_t            state_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;
  logic [15:0]       count_q;
  logic [15:0]       len_q;
  logic [7:0]        xor_q;
  logic [23:0]       asm_q;
  logic [1:0]        byte_cnt_q;

  logic              accept;
  logic [7:0]        xor_d;
  logic [15:0]       len_d;
  logic [31:0]       word_d;
  logic              oversize;
  logic              last_word;

  // A byte is consumed only when the loader advertises ready; the next
  // checksum, length and word values are all derived from that byte.
  assign accept    = bus.in_valid && in_ready_q;
  assign xor_d     = xor_q ^ bus.in_data;
  assign len_d     = {bus.in_data, len_q[7:0]};
  assign word_d    = {bus.in_data, asm_q};
  assign oversize  = {1'b0, len_d} > MaxWordsC;
  assign last_word = (count_q + 16'd1) == len_q;

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.word_count = count_q;

  // Frame parser: state, word assembly, checksum and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN0;
      in_ready_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        LEN0: begin
          if (accept) begin
            len_q[7:0] <= bus.in_data;
            xor_q      <= xor_d;
            state_q    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len_q <= len_d;
            xor_q <= xor_d;
            if (oversize) begin
              state_q    <= ERROR;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (len_d == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            xor_q      <= xor_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {bus.in_data, asm_q[23:8]};
            if (byte_cnt_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= count_q[ADDR_W-1:0];
              wdata_q <= word_d;
              count_q <= count_q + 16'd1;
              if (last_word) begin
                state_q <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (accept) begin
            xor_q      <= xor_d;
            in_ready_q <= 1'b0;
            if (xor_d == 8'h00) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (bus.restart) begin
            state_q    <= LEN0;
            in_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= LEN0;
        end
      endcase
    end
  end

endmodule
